// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the execute-stage adder arbiter.
//   op_e    : operation encoding carried on reqN_op
//   state_e : response FSM states (IDLE = nothing held, RESP = result held)
//   DATA_W  : datapath width of operands and result
// ---------------------------------------------------------------------------
package addsub_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PADD = 2'b10,
    OP_RED  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/addsub_16bit.sv
// ---------------------------------------------------------------------------
// addsub_16bit
// Purely combinational saturating adder/subtractor.
//   padd : per-nibble signed add (or subtract when sub=1), each nibble
//          saturating to 0x7 / 0x8
//   red  : reduction - signed sum of all eight 4-bit nibbles of a and b,
//          sign-extended to 16 bits (range -64..56, never saturates)
//   sub  : subtract b from a (ADD/SUB and PADD modes)
//   a, b : 16-bit signed operands
//   s    : 16-bit result
// Mode priority is red, then padd, then plain ADD/SUB.
// ---------------------------------------------------------------------------
module addsub_16bit
  import addsub_pkg::*;
(
  input  logic              padd,
  input  logic              red,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  // One signed nibble lane: 5-bit sum, clamp when the two top bits differ.
  function automatic logic [3:0] nib_sat(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       neg);
    logic [3:0] y_eff;
    logic [4:0] sum;
    y_eff = neg ? ~y : y;
    sum   = {x[3], x} + {y_eff[3], y_eff} + {4'd0, neg};
    if (sum[4] != sum[3]) begin
      nib_sat = sum[4] ? 4'h8 : 4'h7;
    end else begin
      nib_sat = sum[3:0];
    end
  endfunction

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_wide;
  logic [DATA_W-1:0] w_full;
  logic [DATA_W-1:0] w_padd;
  logic [DATA_W-1:0] w_red;

  // Subtraction as a + ~b + 1 in 17 bits; overflow shows as bit16 != bit15.
  assign w_b_eff = sub ? ~b : b;
  assign w_wide  = {a[DATA_W-1], a} + {w_b_eff[DATA_W-1], w_b_eff}
                 + {{DATA_W{1'b0}}, sub};

  always_comb begin
    w_full = w_wide[DATA_W-1:0];
    if (w_wide[DATA_W] != w_wide[DATA_W-1]) begin
      w_full = w_wide[DATA_W] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_comb begin
    w_padd = '0;
    for (int i = 0; i < 4; i++) begin
      w_padd[4*i +: 4] = nib_sat(a[4*i +: 4], b[4*i +: 4], sub);
    end
  end

  always_comb begin
    w_red = '0;
    for (int i = 0; i < 4; i++) begin
      w_red = w_red + {{12{a[4*i+3]}}, a[4*i +: 4]}
                    + {{12{b[4*i+3]}}, b[4*i +: 4]};
    end
  end

  always_comb begin
    s = w_full;
    if (red) begin
      s = w_red;
    end else if (padd) begin
      s = w_padd;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
// Shares the single addsub_16bit between the execute ALU (requester 0) and
// the address/branch unit (requester 1). One result register feeds a
// valid/ready response channel tagged with the issuing requester.
//
// Parameters:
//   FIXED_PRIO : 0 = round-robin on contention, 1 = requester 0 always wins
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid / reqN_ready  : request handshake, N = 0,1
//   reqN_op, reqN_a, reqN_b  : operation and operands
//   rsp_valid / rsp_ready    : response handshake
//   rsp_id, rsp_s            : issuing requester and 16-bit result
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both high on the rising clock edge. A requester keeps op/a/b
// stable while valid=1 and ready=0. reqN_ready never depends on rsp_s.
// rsp_valid is the FSM state itself (RESP), so it doubles as state debug.
// ---------------------------------------------------------------------------
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_s
);

  state_e            r_state;
  logic              r_ptr;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_s;

  logic              w_any;
  logic              w_grant;
  logic              w_can_accept;
  logic              w_hs;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_sub;
  logic              w_padd;
  logic              w_red;
  logic [DATA_W-1:0] w_s;

  assign w_any = req0_valid | req1_valid;

  // A lone requester wins outright (req1_valid alone -> 1, else 0); on
  // contention the pointer decides unless fixed priority is selected.
  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
    end
  end

  // Accept while empty, or while the held result leaves this same cycle.
  assign w_can_accept = (r_state == IDLE) | rsp_ready;
  assign req0_ready   = w_can_accept & req0_valid & ~w_grant;
  assign req1_ready   = w_can_accept & req1_valid &  w_grant;
  assign w_hs         = req0_ready | req1_ready;

  // Adder inputs are forced to zero when nobody is requesting.
  always_comb begin
    w_op = 2'b00;
    w_a  = '0;
    w_b  = '0;
    if (w_any) begin
      w_op = w_grant ? req1_op : req0_op;
      w_a  = w_grant ? req1_a  : req0_a;
      w_b  = w_grant ? req1_b  : req0_b;
    end
  end

  assign w_sub  = w_any & (w_op == OP_SUB);
  assign w_padd = w_any & (w_op == OP_PADD);
  assign w_red  = w_any & (w_op == OP_RED);

  addsub_16bit u_addsub (
    .padd (w_padd),
    .red  (w_red),
    .sub  (w_sub),
    .a    (w_a),
    .b    (w_b),
    .s    (w_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_rsp_id <= 1'b0;
      r_rsp_s  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_state  <= RESP;
            r_rsp_s  <= w_s;
            r_rsp_id <= w_grant;
            r_ptr    <= ~w_grant;
          end
        end
        RESP: begin
          if (w_hs) begin
            // Retire and reload in the same cycle: stay in RESP.
            r_rsp_s  <= w_s;
            r_rsp_id <= w_grant;
            r_ptr    <= ~w_grant;
          end else if (rsp_ready) begin
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_s     = r_rsp_s;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;
  import addsub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_s;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [15:0] fp_rsp_s;

  addsub_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s)
  );

  addsub_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_s(fp_rsp_s)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: {id, result} of the response in flight.
  logic [16:0] exp_q[$];
  logic        m_ptr;
  logic [15:0] m_last_s;
  logic        m_last_id;
  logic        g_acc0, g_acc1;

  function automatic int snib(input logic [15:0] v, input int i);
    int n;
    n = int'(v[4*i +: 4]);
    return (n >= 8) ? n - 16 : n;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [15:0] ref_op(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    int          r;
    logic [15:0] res;
    res = '0;
    case (op)
      2'b00: begin r = clamp(int'($signed(a)) + int'($signed(b)), -32768, 32767); res = 16'(r); end
      2'b01: begin r = clamp(int'($signed(a)) - int'($signed(b)), -32768, 32767); res = 16'(r); end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          r = clamp(snib(a, i) + snib(b, i), -8, 7);
          res[4*i +: 4] = 4'(r);
        end
      end
      default: begin
        r = 0;
        for (int i = 0; i < 4; i++) r = r + snib(a, i) + snib(b, i);
        res = 16'(r);
      end
    endcase
    return res;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic step();
    logic win, acc, e0, e1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("rsp_id", rsp_id, exp_q[0][16]);
      check("rsp_s", rsp_s, exp_q[0][15:0]);
    end else begin
      check("rsp_s_hold", rsp_s, m_last_s);
      check("rsp_id_hold", rsp_id, m_last_id);
    end
    g_acc0 = 1'b0;
    g_acc1 = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_ptr     = 1'b0;
      m_last_s  = '0;
      m_last_id = 1'b0;
    end else begin
      acc = (exp_q.size() == 0) || rsp_ready;
      win = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      e0  = acc && req0_valid && !win;
      e1  = acc && req1_valid && win;
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (e0 || e1) begin
        m_last_id = win;
        m_last_s  = win ? ref_op(req1_op, req1_a, req1_b)
                        : ref_op(req0_op, req0_a, req0_b);
        exp_q.push_back({m_last_id, m_last_s});
        m_ptr = ~win;
      end
      g_acc0 = e0;
      g_acc1 = e1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic v, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'h7777;
      4: return 16'h8888;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive0(1'b0, 2'b00, 16'h0, 16'h0);
    drive1(1'b0, 2'b00, 16'h0, 16'h0);
    step();
    rst = 1'b0;
  endtask

  logic [15:0] hold_s;

  initial begin
    exp_q.delete();
    m_ptr = 1'b0; m_last_s = '0; m_last_id = 1'b0;
    rst = 1'b1; rsp_ready = 1'b0;
    drive0(1'b0, 2'b00, 16'h0, 16'h0);
    drive1(1'b0, 2'b00, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    step();
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_s", rsp_s, 16'h0000);
    check("rst_id", rsp_id, 1'b0);
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_rdy1", req1_ready, 1'b0);
    rst = 1'b0;

    // Saturating add, same-cycle ready, next-cycle result
    rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 16'h7000, 16'h2000);
    #1 check("add_rdy0", req0_ready, 1'b1);
    step();
    drive0(1'b0, OP_ADD, 16'h0, 16'h0);
    check("add_valid", rsp_valid, 1'b1);
    check("add_id", rsp_id, 1'b0);
    check("add_s", rsp_s, 16'h7FFF);

    // Saturating subtract from requester 1
    drive1(1'b1, OP_SUB, 16'h8000, 16'h0001);
    step();
    drive1(1'b0, OP_ADD, 16'h0, 16'h0);
    check("sub_id", rsp_id, 1'b1);
    check("sub_s", rsp_s, 16'h8000);

    // Parallel nibble add, plain then saturated
    drive0(1'b1, OP_PADD, 16'h1234, 16'h1111);
    step();
    check("padd_s", rsp_s, 16'h2345);
    drive0(1'b1, OP_PADD, 16'h0077, 16'h0011);
    step();
    check("padd_sat_s", rsp_s, 16'h0077);
    drive0(1'b0, OP_ADD, 16'h0, 16'h0);
    step();

    // Round-robin fairness vs fixed priority, from a fresh reset
    do_reset();
    rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 16'h0001, 16'h0002);
    drive1(1'b1, OP_ADD, 16'h0010, 16'h0020);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant0", req0_ready, (i % 2) == 0);
      check("rr_grant1", req1_ready, (i % 2) == 1);
      check("fp_grant0", fp_req0_ready, 1'b1);
      check("fp_grant1", fp_req1_ready, 1'b0);
      step();
      check("rr_rsp_id", rsp_id, 32'(i % 2));
    end

    // Backpressure with both requesters waiting
    rsp_ready = 1'b0;
    hold_s = rsp_s;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0", req0_ready, 1'b0);
      check("bp_rdy1", req1_ready, 1'b0);
      step();
      check("bp_s_stable", rsp_s, hold_s);
      check("bp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_rdy", req0_ready, 1'b1);
    step();
    check("bp_next_valid", rsp_valid, 1'b1);
    check("bp_next_id", rsp_id, 1'b0);

    // Reset while a result is held
    rsp_ready = 1'b0;
    rst = 1'b1;
    drive0(1'b0, OP_ADD, 16'h0, 16'h0);
    drive1(1'b0, OP_ADD, 16'h0, 16'h0);
    step();
    rst = 1'b0;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_s", rsp_s, 16'h0000);
    drive0(1'b1, OP_SUB, 16'h0005, 16'h0003);
    drive1(1'b1, OP_RED, 16'hFFFF, 16'h1234);
    #1;
    check("midrst_rdy0", req0_ready, 1'b1);
    check("midrst_rdy1", req1_ready, 1'b0);
    step();

    // Randomized traffic; requesters hold their operation until accepted
    for (int n = 0; n < 600; n++) begin
      if (!req0_valid || g_acc0)
        drive0($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
      if (!req1_valid || g_acc1)
        drive1($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
